// File: rtl/output_argmax_seq_if.sv
// Handshake bundle between the neuron bank, argmax block and host.
// master: upstream/host side; slave: the argmax block.
interface output_argmax_seq_if #(
  parameter int N_CLASS = 9,
  parameter int DATA_W  = 20,
  parameter int IDX_W   = 4,
  parameter int FCNT_W  = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_CLASS*DATA_W-1:0] a3_flat;
  logic                      out_valid;
  logic                      out_ready;
  logic [IDX_W-1:0]          class_idx;
  logic [DATA_W-1:0]         class_val;
  logic                      confident;
  logic [FCNT_W-1:0]         frame_cnt;

  modport master (
    output in_valid, a3_flat, out_ready,
    input  in_ready, out_valid, class_idx,
    input  class_val, confident, frame_cnt
  );

  modport slave (
    input  in_valid, a3_flat, out_ready,
    output in_ready, out_valid, class_idx,
    output class_val, confident, frame_cnt
  );
endinterface

// File: rtl/output_argmax_seq.sv
// Sequential argmax over a captured activation vector.
// Ports: clk, rst (async high), bus (slave: vector in, result out).
module output_argmax_seq #(
  parameter int N_CLASS = 9,
  parameter int DATA_W  = 20,
  parameter int IDX_W   = 4,
  parameter logic signed [DATA_W-1:0] THRESH = 20'sh04000,
  parameter int FCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  output_argmax_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(N_CLASS - 1);

  logic [1:0]               state;
  logic signed [DATA_W-1:0] buf_q [N_CLASS];
  logic signed [DATA_W-1:0] best_val;
  logic [IDX_W-1:0]         best_idx;
  logic [IDX_W-1:0]         cnt;

  logic                     out_valid_q;
  logic [IDX_W-1:0]         class_idx_q;
  logic [DATA_W-1:0]        class_val_q;
  logic                     confident_q;
  logic [FCNT_W-1:0]        frame_cnt_q;

  logic signed [DATA_W-1:0] cur_val;
  logic signed [DATA_W-1:0] nxt_val;
  logic [IDX_W-1:0]         nxt_idx;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.class_idx = class_idx_q;
  assign bus.class_val = class_val_q;
  assign bus.confident = confident_q;
  assign bus.frame_cnt = frame_cnt_q;

  // Strict compare so ties keep the lower index.
  always_comb begin
    cur_val = buf_q[cnt];
    nxt_val = best_val;
    nxt_idx = best_idx;
    if (cur_val > best_val) begin
      nxt_val = cur_val;
      nxt_idx = cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      for (int i = 0; i < N_CLASS; i++)
        buf_q[i] <= '0;
      best_val    <= '0;
      best_idx    <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      class_idx_q <= '0;
      class_val_q <= '0;
      confident_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_CLASS; i++)
              buf_q[i] <= bus.a3_flat[i*DATA_W +: DATA_W];
            best_val <= bus.a3_flat[DATA_W-1:0];
            best_idx <= '0;
            cnt      <= IDX_W'(1);
            state    <= S_SCAN;
          end
        end
        state == S_SCAN: begin
          best_val <= nxt_val;
          best_idx <= nxt_idx;
          if (cnt == LAST) begin
            class_idx_q <= nxt_idx;
            class_val_q <= nxt_val;
            confident_q <= (nxt_val > THRESH);
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        state == S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax_seq.sv
// Scoreboard bench for output_argmax_seq.
// Small frame counter width so the wrap is reached quickly.
module tb_output_argmax_seq;
  localparam int N   = 9;
  localparam int DW  = 20;
  localparam int IW  = 4;
  localparam int FW  = 4;
  localparam int THR = 16384;

  typedef logic [N*DW-1:0] vec_t;
  typedef struct {
    int idx;
    int val;
    bit conf;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_argmax_seq_if #(
    .N_CLASS(N), .DATA_W(DW), .IDX_W(IW), .FCNT_W(FW)
  ) bus ();

  output_argmax_seq #(
    .N_CLASS(N), .DATA_W(DW), .IDX_W(IW),
    .THRESH(20'sh04000), .FCNT_W(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_fcnt = 0;
  bit manual = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic int elem(vec_t v, int i);
    logic [DW-1:0] e;
    e = v[i*DW +: DW];
    return int'($signed(e));
  endfunction

  function automatic exp_t model(vec_t v);
    exp_t r;
    int best = elem(v, 0);
    int bi = 0;
    for (int i = 1; i < N; i++)
      if (elem(v, i) > best) begin
        best = elem(v, i);
        bi = i;
      end
    r.idx = bi;
    r.val = best;
    r.conf = (best > THR);
    r.acc = 0;
    return r;
  endfunction

  function automatic vec_t mk(int fill, int i1, int val, int i2);
    vec_t v;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = (i == i1 || i == i2) ? DW'(val) : DW'(fill);
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0)
        v[i*DW +: DW] = DW'($urandom);
      else
        v[i*DW +: DW] = DW'((int'($urandom_range(0, 9)) - 4) * 4096);
    end
    return v;
  endfunction

  task automatic send_vec(input vec_t v);
    int t = 0;
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a3_flat = v;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(v);
    e.acc = cyc;
    q.push_back(e);
    bus.in_valid = 1'b0;
    bus.a3_flat = rnd_vec();
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!manual) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    bit prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        continue;
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = q[0];
          if (!prev) chk("latency", cyc - e.acc, N - 1);
          chk("class_idx", bus.class_idx, e.idx);
          chk("class_val", $signed(bus.class_val), e.val);
          chk("confident", bus.confident, e.conf);
          chk("frame_cnt", bus.frame_cnt, exp_fcnt);
          if (bus.out_ready) begin
            void'(q.pop_front());
            exp_fcnt = (exp_fcnt + 1) % (1 << FW);
          end
        end
      end
      prev = bus.out_valid;
    end
  end

  initial begin
    vec_t vb;
    int t;
    bus.in_valid = 1'b0;
    bus.a3_flat = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_class_idx", bus.class_idx, 0);
    chk("rst_class_val", bus.class_val, 0);
    chk("rst_confident", bus.confident, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    manual = 1'b0;

    send_vec(mk(32'h1000, 5, 32'h7000, -1));
    send_vec(mk(32'h0100, 2, 32'h6000, 7));
    send_vec(mk(32'h0800, 8, 32'h3000, -1));
    send_vec(mk(32'h0800, 8, 32'h4000, -1));
    wait_drain();

    manual = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send_vec(mk(32'h0200, 3, 32'h5000, -1));
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid", bus.out_valid, 1);
    vb = mk(32'h0300, 6, 32'h7800, -1);
    bus.in_valid = 1'b1;
    bus.a3_flat = vb;
    repeat (20) begin
      chk("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_out_valid_fall", bus.out_valid, 0);
    chk("bp_in_ready_rise", bus.in_ready, 1);
    send_vec(vb);
    manual = 1'b0;
    wait_drain();

    send_vec(rnd_vec());
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_class_idx", bus.class_idx, 0);
    chk("mid_rst_frame_cnt", bus.frame_cnt, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_fcnt = 0;
    @(negedge clk);
    rst = 1'b0;

    send_vec(mk(-4096, 4, 0, -1));
    for (int i = 0; i < 30; i++) send_vec(rnd_vec());
    wait_drain();
    repeat (2) @(negedge clk);
    chk("final_frame_cnt", bus.frame_cnt, exp_fcnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_argmax_seq.md
Name: output_argmax_seq

Overview:
- Classification back end. Sits directly downstream of the output-layer neuron bank and consumes its 9 sigmoid activations.
- Captures one activation vector through a valid/ready handshake, then scans the elements one per clock to find the argmax.
- Presents the winning class index, its activation, a confidence flag and a running frame count to the system/host side.

Parameters:
- N_CLASS, 9, number of activations per vector (>=2).
- DATA_W, 20, activation width; signed, 15 fractional bits (1.0 = 20'sh08000).
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= N_CLASS.
- THRESH, 20'sh04000, confidence threshold (0.5); signed compare.
- FCNT_W, 16, frame counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  activation vector present.
- in_ready  out  1  block can accept a vector.
- a3_flat  in  N_CLASS*DATA_W  activations; element i at bits [i*DATA_W +: DATA_W], i=0 is a3_1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- class_idx  out  IDX_W  0-based index of the maximum element.
- class_val  out  DATA_W  activation value of that element.
- confident  out  1  class_val > THRESH (strict, signed).
- frame_cnt  out  FCNT_W  number of results consumed, wraps modulo 2^FCNT_W.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; out_valid=0, class_idx=0, class_val=0, confident=0, frame_cnt=0; internal buffer, best and cnt cleared. in_ready reads 1 while rst is high and after reset.
- States: IDLE, SCAN, DONE. in_ready = (state==IDLE), decoded combinationally from the state register only. There is no combinational path from in_valid or out_ready to in_ready.
- IDLE: on in_valid&&in_ready at edge k:
  - register all of a3_flat into the buffer;
  - best_val=element0, best_idx=0, cnt=1;
  - go to SCAN.
- IDLE: a3_flat is ignored when there is no handshake.
- SCAN: each edge compares buffer[cnt] with best_val, signed.
  - If strictly greater, best_val/best_idx take buffer[cnt] and cnt.
  - Ties keep the lower index.
  - When cnt==N_CLASS-1, the final compare is applied on that edge and the result registers load:
    - class_idx, class_val take the final best;
    - confident = (final best_val > THRESH);
    - out_valid=1;
    - go to DONE.
  - Otherwise cnt increments.
- Latency: out_valid is high after edge k+N_CLASS-1 (edge k+8 for the default).
- Input changes after capture have no effect on the current scan.
- DONE: class_idx, class_val, confident and out_valid are held stable until out_valid&&out_ready. On that edge:
  - out_valid=0;
  - frame_cnt increments (wrapping to 0 from all-ones);
  - go to IDLE.
- The result registers keep their last values after consumption; only out_valid drops.
- in_ready is 0 on the consume cycle. The next vector is accepted no earlier than the edge after consumption, so throughput is at most one vector per N_CLASS+1 cycles.
- in_valid while in SCAN or DONE is ignored; the upstream source holds it, per handshake rules.
- out_ready while not in DONE has no effect.
- Arithmetic: comparisons are signed, at full DATA_W, with no truncation. Negative values are legal and ordered correctly.
- Reset asserted mid-SCAN or mid-DONE: immediate return to the reset values. The partial result is discarded and frame_cnt is not incremented.

Test Plan:
- Normal winner:
  - Stimulus: all elements 20'sh01000 except element 5 = 20'sh07000; accept at edge k.
  - Required: out_valid rises after edge k+8; class_idx=5, class_val=20'sh07000, confident=1; frame_cnt 0->1 on consume.
- Tie:
  - Stimulus: elements 2 and 7 = 20'sh06000, others 20'sh00100.
  - Required: class_idx=2, class_val=20'sh06000.
- Low confidence and threshold boundary:
  - Stimulus: max element 8 = 20'sh03000.
  - Required: class_idx=8, confident=0.
  - Repeat with max exactly 20'sh04000: confident=0 (strict compare).
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; drive in_valid=1 with a new vector throughout.
  - Required: outputs stable, in_ready=0, new vector not captured.
  - Then release out_ready for 1 cycle: out_valid falls, in_ready rises next cycle, and the new vector is accepted on the following handshake.
- Reset mid-scan and negative values:
  - Stimulus: assert rst 3 cycles after accept.
  - Required: out_valid=0, class_idx=0, frame_cnt=0 asynchronously, in_ready=1.
  - Then send all elements 20'shFF000 except element 4 = 20'sh00000. Required: class_idx=4, confident=0.
- Frame counter wrap:
  - Stimulus: preload via 65536 consumed frames (or FCNT_W=4 build with 16 frames).
  - Required: frame_cnt wraps to 0 with no other side effect.
